complex_result_join: RTL and testbench

- Downstream of double_complexnumber_sub; consumes its two independent result streams, output_z_real and output_z_imag.
- Each stream uses the stb/ack handshake. The two streams may complete on different cycles.
- Block acks each stream independently and pairs one real with one imaginary result into a complex word.
- Complex words are buffered in a small FIFO and presented to the next stage on a valid/ready interface.

---
 rtl/complex_result_join_if.sv | 34 +++
 rtl/complex_result_join.sv | 102 ++++++++++
 tb/tb_complex_result_join.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_result_join_if.sv
// Handshake bundle for complex_result_join: two stb/ack result
// streams in, one valid/ready complex-word stream out.
interface complex_result_join_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] input_real;
    logic             input_real_stb;
    logic             input_real_ack;
    logic [WIDTH-1:0] input_imag;
    logic             input_imag_stb;
    logic             input_imag_ack;
    logic [WIDTH-1:0] out_real;
    logic [WIDTH-1:0] out_imag;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output input_real, input_real_stb,
        input  input_real_ack,
        output input_imag, input_imag_stb,
        input  input_imag_ack,
        input  out_real, out_imag, out_valid,
        output out_ready
    );

    modport slave (
        input  input_real, input_real_stb,
        output input_real_ack,
        input  input_imag, input_imag_stb,
        output input_imag_ack,
        output out_real, out_imag, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/complex_result_join.sv
// Pairs independent real/imag result streams into complex words
// and buffers them in a small FIFO with a valid/ready output.
module complex_result_join #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    complex_result_join_if.slave bus,
    output logic [CW-1:0]        level,
    output logic [15:0]          pair_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0]   real_q, real_d;
    logic [WIDTH-1:0]   imag_q, imag_d;
    logic               real_full_q, real_full_d;
    logic               imag_full_q, imag_full_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      level_q, level_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] head;
    logic               push, pop, valid;

    assign valid = (level_q != '0);
    assign push  = real_full_q & imag_full_q & (level_q != FULL);
    assign pop   = valid & bus.out_ready;
    assign head  = mem_q[rptr_q];

    // Acks come straight from the full flags; no path from stb.
    assign bus.input_real_ack = ~real_full_q;
    assign bus.input_imag_ack = ~imag_full_q;
    assign bus.out_valid      = valid;
    assign bus.out_real       = valid ? head[2*WIDTH-1:WIDTH] : '0;
    assign bus.out_imag       = valid ? head[WIDTH-1:0] : '0;
    assign level              = level_q;
    assign pair_count         = cnt_q;

    always_comb begin
        real_d      = real_q;
        imag_d      = imag_q;
        real_full_d = real_full_q;
        imag_full_d = imag_full_q;
        if (push) begin
            real_full_d = 1'b0;
            imag_full_d = 1'b0;
        end
        if (bus.input_real_stb && !real_full_q) begin
            real_d      = bus.input_real;
            real_full_d = 1'b1;
        end
        if (bus.input_imag_stb && !imag_full_q) begin
            imag_d      = bus.input_imag;
            imag_full_d = 1'b1;
        end
    end

    always_comb begin
        wptr_d  = push ? AW'(wptr_q + 1'b1) : wptr_q;
        rptr_d  = pop ? AW'(rptr_q + 1'b1) : rptr_q;
        cnt_d   = push ? cnt_q + 16'd1 : cnt_q;
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            real_q      <= '0;
            imag_q      <= '0;
            real_full_q <= 1'b0;
            imag_full_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
        end else begin
            real_q      <= real_d;
            imag_q      <= imag_d;
            real_full_q <= real_full_d;
            imag_full_q <= imag_full_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {real_q, imag_q};
        end
    end
endmodule

// File: tb/tb_complex_result_join.sv
// Directed bench for complex_result_join: reset, pairing, skew,
// backpressure, concurrent push/pop and pair_count wrap.
module tb_complex_result_join;
    logic        clk;
    logic        rst;
    logic [2:0]  level;
    logic [15:0] pair_count;
    int          errors;
    int          checks;

    complex_result_join_if #(.WIDTH(64)) bus ();

    complex_result_join #(
        .WIDTH(64),
        .DEPTH(4),
        .CW(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .level(level),
        .pair_count(pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) until both slots are free, then strobes one pair
    // for exactly one edge. Returns at capture edge + 1.
    task automatic offer_pair(input logic [63:0] r, input logic [63:0] i);
        int n;
        n = 0;
        while (!(bus.input_real_ack && bus.input_imag_ack) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL offer_timeout: acks=%b%b required 11",
                bus.input_real_ack, bus.input_imag_ack);
        end
        bus.input_real     = r;
        bus.input_imag     = i;
        bus.input_real_stb = 1'b1;
        bus.input_imag_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.input_real_stb = 1'b0;
        bus.input_imag_stb = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (level !== 3'd0 || pair_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: level=%0d cnt=%0d want 0 0", level, pair_count);
        end
        checks++;
        if (bus.input_real_ack !== 1'b1 || bus.input_imag_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_acks: got %b%b want 11",
                bus.input_real_ack, bus.input_imag_ack);
        end
        checks++;
        if (bus.out_real !== 64'd0 || bus.out_imag !== 64'd0) begin
            errors++;
            $display("FAIL reset_head: got %h %h want 0 0", bus.out_real, bus.out_imag);
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk);
        #1;
        offer_pair(64'h1111, 64'h2222);
        @(posedge clk);
        #1;
        checks++;
        if (level !== 3'd1 || pair_count !== 16'd1) begin
            errors++;
            $display("FAIL pre_rst_state: level=%0d cnt=%0d want 1 1", level, pair_count);
        end
        bus.input_real     = 64'h3333;
        bus.input_real_stb = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.input_real_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_capture_ack: got %b want 0", bus.input_real_ack);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.input_real_ack !== 1'b1 || bus.input_imag_ack !== 1'b1 ||
            bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flags: acks=%b%b valid=%b want 11 0",
                bus.input_real_ack, bus.input_imag_ack, bus.out_valid);
        end
        checks++;
        if (level !== 3'd0 || pair_count !== 16'd0 || bus.out_real !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_state: level=%0d cnt=%0d real=%h want 0 0 0",
                level, pair_count, bus.out_real);
        end
        bus.input_real_stb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_pair;
        bus.input_real     = 64'hC020000000000000;
        bus.input_imag     = 64'h4044400000000000;
        bus.input_real_stb = 1'b1;
        bus.input_imag_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.input_real_stb = 1'b0;
        bus.input_imag_stb = 1'b0;
        checks++;
        if (bus.input_real_ack !== 1'b0 || bus.input_imag_ack !== 1'b0 ||
            bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after_n: acks=%b%b valid=%b want 00 0",
                bus.input_real_ack, bus.input_imag_ack, bus.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || level !== 3'd1 || pair_count !== 16'd1) begin
            errors++;
            $display("FAIL single_push: valid=%b level=%0d cnt=%0d want 1 1 1",
                bus.out_valid, level, pair_count);
        end
        checks++;
        if (bus.out_real !== 64'hC020000000000000 ||
            bus.out_imag !== 64'h4044400000000000) begin
            errors++;
            $display("FAIL single_head: got %h %h want c020000000000000 4044400000000000",
                bus.out_real, bus.out_imag);
        end
        checks++;
        if (bus.input_real_ack !== 1'b1 || bus.input_imag_ack !== 1'b1) begin
            errors++;
            $display("FAIL single_ack_rise: got %b%b want 11",
                bus.input_real_ack, bus.input_imag_ack);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (level !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: level=%0d valid=%b want 0 0", level, bus.out_valid);
        end
    endtask

    task automatic test_skew;
        bus.input_real     = 64'hAAAA0000AAAA0001;
        bus.input_real_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.input_real_stb = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.input_real_ack !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL skew_wait%0d: ack=%b valid=%b want 0 0",
                    k, bus.input_real_ack, bus.out_valid);
            end
        end
        bus.input_imag     = 64'hBBBB0000BBBB0002;
        bus.input_imag_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.input_imag_stb = 1'b0;
        checks++;
        if (bus.input_real_ack !== 1'b0 || bus.input_imag_ack !== 1'b0 ||
            bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL skew_n5: acks=%b%b valid=%b want 00 0",
                bus.input_real_ack, bus.input_imag_ack, bus.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || level !== 3'd1 || pair_count !== 16'd2 ||
            bus.out_real !== 64'hAAAA0000AAAA0001 ||
            bus.out_imag !== 64'hBBBB0000BBBB0002) begin
            errors++;
            $display("FAIL skew_push: valid=%b level=%0d cnt=%0d head=%h %h",
                bus.out_valid, level, pair_count, bus.out_real, bus.out_imag);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [63:0] rv [5];
        logic [63:0] iv [5];
        rv = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h14};
        iv = '{64'h20, 64'h21, 64'h22, 64'h23, 64'h24};
        for (int k = 0; k < 5; k++) offer_pair(rv[k], iv[k]);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (level !== 3'd4 || bus.input_real_ack !== 1'b0 ||
            bus.input_imag_ack !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: level=%0d acks=%b%b want 4 00",
                level, bus.input_real_ack, bus.input_imag_ack);
        end
        checks++;
        if (bus.out_real !== 64'h10 || bus.out_imag !== 64'h20) begin
            errors++;
            $display("FAIL bp_head: got %h %h want 10 20", bus.out_real, bus.out_imag);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (level !== 3'd3 || bus.input_real_ack !== 1'b0 || bus.out_real !== 64'h11) begin
            errors++;
            $display("FAIL bp_pop: level=%0d ack=%b head=%h want 3 0 11",
                level, bus.input_real_ack, bus.out_real);
        end
        @(posedge clk);
        #1;
        checks++;
        if (level !== 3'd4 || bus.input_real_ack !== 1'b1 ||
            bus.input_imag_ack !== 1'b1) begin
            errors++;
            $display("FAIL bp_refill: level=%0d acks=%b%b want 4 11",
                level, bus.input_real_ack, bus.input_imag_ack);
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_real !== rv[k] ||
                bus.out_imag !== iv[k]) begin
                errors++;
                $display("FAIL bp_drain%0d: valid=%b head=%h %h want %h %h",
                    k, bus.out_valid, bus.out_real, bus.out_imag, rv[k], iv[k]);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (level !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: level=%0d valid=%b want 0 0", level, bus.out_valid);
        end
    endtask

    task automatic test_concurrent;
        logic [63:0] qr[$];
        logic [63:0] qi[$];
        logic [63:0] r;
        logic [63:0] i;
        for (int k = 0; k < 2; k++) begin
            r = {$urandom, $urandom};
            i = {$urandom, $urandom};
            qr.push_back(r);
            qi.push_back(i);
            offer_pair(r, i);
        end
        @(posedge clk);
        #1;
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL cc_prefill: level=%0d want 2", level);
        end
        for (int k = 0; k < 10; k++) begin
            r = {$urandom, $urandom};
            i = {$urandom, $urandom};
            offer_pair(r, i);
            qr.push_back(r);
            qi.push_back(i);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_real !== qr[0] ||
                bus.out_imag !== qi[0]) begin
                errors++;
                $display("FAIL cc_order%0d: head=%h %h want %h %h",
                    k, bus.out_real, bus.out_imag, qr[0], qi[0]);
            end
            void'(qr.pop_front());
            void'(qi.pop_front());
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            checks++;
            if (level !== 3'd2) begin
                errors++;
                $display("FAIL cc_level%0d: level=%0d want 2", k, level);
            end
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.out_real !== qr[0] || bus.out_imag !== qi[0]) begin
                errors++;
                $display("FAIL cc_tail%0d: head=%h %h want %h %h",
                    k, bus.out_real, bus.out_imag, qr[0], qi[0]);
            end
            void'(qr.pop_front());
            void'(qi.pop_front());
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_wrap;
        // Preload the counter near the top so the wrap is reached quickly.
        force dut.cnt_q = 16'hFFF0;
        #1;
        release dut.cnt_q;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 15; k++) offer_pair(64'(k), 64'(k + 100));
        @(posedge clk);
        #1;
        checks++;
        if (pair_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_top: cnt=%h want ffff", pair_count);
        end
        offer_pair(64'h55, 64'h66);
        @(posedge clk);
        #1;
        checks++;
        if (pair_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: cnt=%h want 0000", pair_count);
        end
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        errors             = 0;
        checks             = 0;
        rst                = 1'b1;
        bus.input_real     = '0;
        bus.input_imag     = '0;
        bus.input_real_stb = 1'b0;
        bus.input_imag_stb = 1'b0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_reset_mid();
        test_single_pair();
        test_skew();
        test_backpressure();
        test_concurrent();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
